cube_scan_driver: RTL and testbench

Layer-multiplexed scan driver for the 8×8×8 LED cube. Takes the 512-bit frame produced by the frame buffer (`frame_cube_flat`), snapshots it at each frame boundary so no frame tears, serializes one 64-bit layer at a time into the column shift-register chain, and drives the one-hot layer-select lines with blanking between layers. It sits between the frame buffer and the board pins, and is the reader end of the frame-buffer interface.

---
 rtl/cube_scan_driver_pkg.sv | 22 ++
 rtl/cube_scan_driver_if.sv | 36 +++
 rtl/cube_scan_driver_layer_serializer.sv | 79 +++++++
 rtl/cube_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_cube_scan_driver.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cube_scan_driver_pkg.sv
// Shared geometry of the 8x8x8 LED cube and a helper that extracts one layer
// from a flattened frame.
//
// Contents:
//   CUBE_LAYERS  number of layers (one-hot layer_sel width)
//   LAYER_BITS   bits per layer (length of the column shift chain)
//   FRAME_BITS   bits per flattened frame
//   layer_word   returns layer L of a frame, bits [64L+63:64L]
package cube_scan_driver_pkg;

    localparam int CUBE_LAYERS = 8;
    localparam int LAYER_BITS  = 64;
    localparam int FRAME_BITS  = 512;

    function automatic logic [LAYER_BITS-1:0] layer_word(
        input logic [FRAME_BITS-1:0] frame,
        input logic [2:0]            layer
    );
        return frame[int'(layer)*LAYER_BITS +: LAYER_BITS];
    endfunction

endpackage

// File: rtl/cube_scan_driver_if.sv
// Bundle of the frame input and the board-pin outputs of the scan driver.
//
// Signals:
//   frame_cube_flat  512-bit frame from the frame buffer
//   sr_data          serial column data
//   sr_clk           column chain shift clock (chain samples on rising edge)
//   sr_latch         storage-register latch pulse
//   sr_oe_n          column output enable, active-low
//   layer_sel        one-hot layer drive, active-high
//   scan_layer       index of the layer currently lit
//   frame_done       one-cycle pulse at the end of layer 7's lit period
//
// master: the scan driver.  slave: the frame source / board side.
interface cube_scan_driver_if;
    import cube_scan_driver_pkg::*;

    logic [FRAME_BITS-1:0]  frame_cube_flat;
    logic                   sr_data;
    logic                   sr_clk;
    logic                   sr_latch;
    logic                   sr_oe_n;
    logic [CUBE_LAYERS-1:0] layer_sel;
    logic [2:0]             scan_layer;
    logic                   frame_done;

    modport master (
        input  frame_cube_flat,
        output sr_data, sr_clk, sr_latch, sr_oe_n, layer_sel, scan_layer, frame_done
    );

    modport slave (
        output frame_cube_flat,
        input  sr_data, sr_clk, sr_latch, sr_oe_n, layer_sel, scan_layer, frame_done
    );

endinterface

// File: rtl/cube_scan_driver_layer_serializer.sv
// Serializes one 64-bit layer word, MSB first, into the column shift chain.
// Each bit is presented with sr_clk low for CLK_DIV cycles, then high for
// CLK_DIV cycles; a full word takes 128*CLK_DIV cycles and ends with sr_clk low.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   word        layer word, captured on start
//   start       one-cycle request to begin shifting word
//   sr_data     serial data, changes only at start or when sr_clk falls
//   sr_clk      shift clock
//   done        high during the final cycle of a shift
module layer_serializer
    import cube_scan_driver_pkg::*;
#(
    parameter int CLK_DIV = 2
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LAYER_BITS-1:0] word,
    input  logic                  start,
    output logic                  sr_data,
    output logic                  sr_clk,
    output logic                  done
);

    // A divider of CLK_DIV=1 would be zero bits wide; keep one bit that stays 0.
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [LAYER_BITS-1:0] shreg_q;
    logic                  busy_q;
    logic                  sr_clk_q;
    logic [DIV_W-1:0]      div_q;
    logic [6:0]            bit_cnt_q;
    logic                  tick;

    assign tick    = busy_q && (div_q == DIV_LAST);
    // Final cycle: the high half of bit 0 is expiring and sr_clk is about to fall.
    assign done    = tick && sr_clk_q && (bit_cnt_q == 7'd63);
    assign sr_data = shreg_q[LAYER_BITS-1];
    assign sr_clk  = sr_clk_q;

    // Half-period divider; the falling edge advances to the next bit, so data
    // is always settled for CLK_DIV cycles before the chain samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            busy_q    <= 1'b0;
            sr_clk_q  <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
        end else if (start) begin
            shreg_q   <= word;
            busy_q    <= 1'b1;
            sr_clk_q  <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
        end else if (busy_q) begin
            if (tick) begin
                div_q <= '0;
                if (!sr_clk_q) begin
                    sr_clk_q <= 1'b1;
                end else begin
                    sr_clk_q  <= 1'b0;
                    bit_cnt_q <= bit_cnt_q + 7'd1;
                    if (bit_cnt_q == 7'd63) begin
                        busy_q <= 1'b0;
                    end else begin
                        shreg_q <= {shreg_q[LAYER_BITS-2:0], 1'b0};
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cube_scan_driver.sv
// Layer-multiplexed scan driver for the 8x8x8 LED cube. Snapshots the frame at
// the start of every layer-0 shift so a frame never tears, serializes the next
// layer while the current one is lit, and blanks all layers around each latch.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         cube_scan_driver_if.master: frame input and board-pin outputs
//
// Parameters:
//   CLK_DIV       clk cycles per half-period of sr_clk (>=1)
//   LAYER_DWELL   minimum clk cycles each layer is lit
//   BLANK_CYCLES  clk cycles all layers are dark before each latch (>=1)
module cube_scan_driver
    import cube_scan_driver_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int LAYER_DWELL  = 20000,
    parameter int BLANK_CYCLES = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    cube_scan_driver_if.master  bus
);

    typedef enum logic [1:0] {INIT_SHIFT, BLANK, LATCH, SHOW} scan_state_t;

    localparam int                 DWELL_W   = (LAYER_DWELL > 0) ? $clog2(LAYER_DWELL + 1) : 1;
    localparam int                 BLANK_W   = $clog2(BLANK_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(LAYER_DWELL);
    localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYCLES);

    scan_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0]  snap_q;
    logic [DWELL_W-1:0]     dwell_cnt_q;
    logic [BLANK_W-1:0]     blank_cnt_q;
    logic [2:0]             next_layer_q;
    logic [2:0]             scan_layer_q;
    logic                   init_pending_q;
    logic                   shift_done_q;
    logic                   sr_latch_q;
    logic                   sr_oe_n_q;
    logic [CUBE_LAYERS-1:0] layer_sel_q;

    logic                   ser_start;
    logic                   ser_done;
    logic [LAYER_BITS-1:0]  ser_word;
    logic                   take_snap;
    logic                   show_exit;
    logic                   dwell_met;
    logic                   blank_met;
    logic                   ser_data;
    logic                   ser_clk;

    assign dwell_met = (32'(dwell_cnt_q) + 32'd1) >= 32'(LAYER_DWELL);
    assign blank_met = (32'(blank_cnt_q) + 32'd1) >= 32'(BLANK_CYCLES);

    layer_serializer #(.CLK_DIV(CLK_DIV)) u_serializer (
        .clk     (clk),
        .rst_n   (rst_n),
        .word    (ser_word),
        .start   (ser_start),
        .sr_data (ser_data),
        .sr_clk  (ser_clk),
        .done    (ser_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_SHIFT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus shifter control. A layer-0 shift always reads the live
    // frame directly, because the snapshot of that frame is being taken on the
    // same edge. SHOW ends only when both the dwell and the shift have finished,
    // so a latch never captures a partial word.
    always_comb begin
        state_d   = state_q;
        ser_start = 1'b0;
        take_snap = 1'b0;
        show_exit = 1'b0;
        ser_word  = layer_word(snap_q, next_layer_q + 3'd1);
        case (state_q)
            INIT_SHIFT: begin
                if (init_pending_q) begin
                    ser_start = 1'b1;
                    take_snap = 1'b1;
                end
                if (ser_done) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (blank_met) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                ser_start = 1'b1;
                take_snap = (next_layer_q == 3'd7);
                state_d   = SHOW;
            end
            SHOW: begin
                if (dwell_met && (ser_done || shift_done_q)) begin
                    show_exit = 1'b1;
                    state_d   = BLANK;
                end
            end
            default: state_d = INIT_SHIFT;
        endcase
        if (take_snap) begin
            ser_word = bus.frame_cube_flat[LAYER_BITS-1:0];
        end
    end

    // Snapshot, counters, layer tracking and registered pin drive. Pins are
    // derived from the next state so they switch exactly on BLANK/LATCH/SHOW
    // entry with no decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q         <= '0;
            dwell_cnt_q    <= '0;
            blank_cnt_q    <= '0;
            next_layer_q   <= 3'd0;
            scan_layer_q   <= 3'd0;
            init_pending_q <= 1'b1;
            shift_done_q   <= 1'b0;
            sr_latch_q     <= 1'b0;
            sr_oe_n_q      <= 1'b1;
            layer_sel_q    <= '0;
        end else begin
            if (take_snap) begin
                snap_q <= bus.frame_cube_flat;
            end
            if (ser_start) begin
                init_pending_q <= 1'b0;
                shift_done_q   <= 1'b0;
            end else if (ser_done) begin
                shift_done_q <= 1'b1;
            end

            if (state_d != state_q) begin
                dwell_cnt_q <= '0;
                blank_cnt_q <= '0;
            end else begin
                if (state_q == SHOW && dwell_cnt_q != DWELL_MAX) begin
                    dwell_cnt_q <= dwell_cnt_q + 1'b1;
                end
                if (state_q == BLANK && blank_cnt_q != BLANK_MAX) begin
                    blank_cnt_q <= blank_cnt_q + 1'b1;
                end
            end

            if (state_q == LATCH) begin
                scan_layer_q <= next_layer_q;
                next_layer_q <= next_layer_q + 3'd1;
            end

            sr_latch_q  <= (state_d == LATCH);
            sr_oe_n_q   <= (state_d != SHOW);
            layer_sel_q <= (state_d == SHOW)
                         ? (CUBE_LAYERS'(1) << ((state_q == LATCH) ? next_layer_q : scan_layer_q))
                         : '0;
        end
    end

    assign bus.sr_data    = ser_data;
    assign bus.sr_clk     = ser_clk;
    assign bus.sr_latch   = sr_latch_q;
    assign bus.sr_oe_n    = sr_oe_n_q;
    assign bus.layer_sel  = layer_sel_q;
    assign bus.scan_layer = scan_layer_q;
    assign bus.frame_done = show_exit && (scan_layer_q == 3'd7);

endmodule

// File: tb/tb_cube_scan_driver.sv
// Bench for cube_scan_driver. Instance A (LAYER_DWELL=200) is checked every
// cycle against a timeline computed from the layer/frame period arithmetic and
// against the words captured by a model of the column chain. Instance B
// (LAYER_DWELL=10) checks that short dwell stretches SHOW to the shift length.
module tb_cube_scan_driver;
    import cube_scan_driver_pkg::*;

    localparam int CLK_DIV   = 1;
    localparam int DWELL_A   = 200;
    localparam int DWELL_B   = 10;
    localparam int BLANK     = 4;
    localparam int SHIFT_LEN = 128 * CLK_DIV;
    localparam int SHOW_A    = (DWELL_A > SHIFT_LEN) ? DWELL_A : SHIFT_LEN;
    localparam int SHOW_B    = (DWELL_B > SHIFT_LEN) ? DWELL_B : SHIFT_LEN;
    localparam int PERIOD_A  = SHOW_A + BLANK + 1;
    localparam int FIRST     = SHIFT_LEN + BLANK + 1;
    localparam int FRAME_A   = 8 * PERIOD_A;

    logic         clk;
    logic         rst_n;
    logic [511:0] frame;

    cube_scan_driver_if bus_a();
    cube_scan_driver_if bus_b();

    assign bus_a.frame_cube_flat = frame;
    assign bus_b.frame_cube_flat = frame;

    cube_scan_driver #(.CLK_DIV(CLK_DIV), .LAYER_DWELL(DWELL_A), .BLANK_CYCLES(BLANK)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    cube_scan_driver #(.CLK_DIV(CLK_DIV), .LAYER_DWELL(DWELL_B), .BLANK_CYCLES(BLANK)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           n_compared   = 0;
    int           n_mismatched = 0;
    int           tcyc         = 0;
    logic [511:0] mdl_snap;
    logic [63:0]  exp_q[$];
    logic [63:0]  chain;
    logic [63:0]  exp_word;
    logic         prev_a_clk;
    logic         prev_b_clk;
    int           b_rises;
    int           b_show;
    int           rel, slot, pos, lay, off, exp_layer;
    logic         lit, latch_exp, clk_exp, done_exp;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, tcyc, observed, expected);
        end
    endtask

    // Cycle index tcyc counts from the first clock edge after reset release.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            checkOutput("rst_oe_n",       64'(bus_a.sr_oe_n),    64'd1);
            checkOutput("rst_layer_sel",  64'(bus_a.layer_sel),  64'd0);
            checkOutput("rst_sr_clk",     64'(bus_a.sr_clk),     64'd0);
            checkOutput("rst_sr_latch",   64'(bus_a.sr_latch),   64'd0);
            checkOutput("rst_frame_done", 64'(bus_a.frame_done), 64'd0);
            checkOutput("rst_scan_layer", 64'(bus_a.scan_layer), 64'd0);
            checkOutput("rst_b_oe_n",     64'(bus_b.sr_oe_n),    64'd1);
            checkOutput("rst_b_layer_sel",64'(bus_b.layer_sel),  64'd0);
            tcyc       = 0;
            exp_q.delete();
            chain      = '0;
            prev_a_clk = 1'b0;
            prev_b_clk = 1'b0;
            b_rises    = 0;
            b_show     = 0;
        end else begin
            rel  = tcyc - FIRST;
            slot = (rel >= 0) ? rel / PERIOD_A : -1;
            pos  = (rel >= 0) ? rel % PERIOD_A : -1;

            // Every layer-0 shift starts from a fresh copy of the frame; every
            // shift start queues the word that the next latch must capture.
            if (tcyc == 0) begin
                mdl_snap = frame;
                exp_q.push_back(mdl_snap[63:0]);
            end
            if (pos == 0) begin
                if (slot % 8 == 7) mdl_snap = frame;
                lay = (slot + 1) % 8;
                exp_q.push_back(mdl_snap[lay*64 +: 64]);
            end

            exp_layer = (slot >= 0) ? slot % 8 : 0;
            lit       = (pos >= 0) && (pos < SHOW_A);
            latch_exp = (tcyc == FIRST - 1) || (pos == PERIOD_A - 1);
            done_exp  = lit && (pos == SHOW_A - 1) && (exp_layer == 7);
            off       = (tcyc < SHIFT_LEN) ? tcyc : ((pos >= 0 && pos < SHIFT_LEN) ? pos : -1);
            clk_exp   = (off >= 0) && ((off % (2 * CLK_DIV)) >= CLK_DIV);

            checkOutput("sr_latch",   64'(bus_a.sr_latch),   64'(latch_exp));
            checkOutput("sr_oe_n",    64'(bus_a.sr_oe_n),    64'(!lit));
            checkOutput("layer_sel",  64'(bus_a.layer_sel),  lit ? (64'd1 << exp_layer) : 64'd0);
            checkOutput("sr_clk",     64'(bus_a.sr_clk),     64'(clk_exp));
            checkOutput("frame_done", 64'(bus_a.frame_done), 64'(done_exp));
            if (lit) checkOutput("scan_layer", 64'(bus_a.scan_layer), 64'(exp_layer));

            if (bus_a.sr_clk && !prev_a_clk) chain = {chain[62:0], bus_a.sr_data};
            prev_a_clk = bus_a.sr_clk;
            if (latch_exp && exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                checkOutput("latched_word", chain, exp_word);
            end

            if (bus_b.sr_clk && !prev_b_clk) b_rises++;
            prev_b_clk = bus_b.sr_clk;
            if (bus_b.sr_latch) begin
                checkOutput("b_rises_per_latch", 64'(b_rises), 64'd64);
                b_rises = 0;
            end
            if (!bus_b.sr_oe_n) begin
                b_show++;
            end else if (b_show > 0) begin
                checkOutput("b_show_len", 64'(b_show), 64'(SHOW_B));
                b_show = 0;
            end

            tcyc++;
        end
    end

    // All stimulus changes land at negedge+2, between the monitor and the next edge.
    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [511:0] f, input int hold);
        @(negedge clk);
        #2;
        frame = f;
        run_cycles(hold);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Waits until the cycle just checked lies in SHOW(layer) at the given offset.
    task automatic wait_for_slot(input int layer, input int offset);
        int cur;
        for (int i = 0; i < 2 * FRAME_A; i++) begin
            @(negedge clk);
            #2;
            cur = tcyc - 1;
            if (rst_n && cur >= FIRST && ((cur - FIRST) / PERIOD_A) % 8 == layer
                && ((cur - FIRST) % PERIOD_A) == offset) break;
        end
    endtask

    function automatic logic [511:0] random_frame();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        frame = '0;
        run_cycles(5);

        frame = {448'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        release_reset();
        run_cycles(FIRST + 9 * PERIOD_A + 10);

        applyStimulus({448'h0, 64'h0000_0000_0000_0001}, 2 * FRAME_A);
        applyStimulus({448'h0, 64'h8000_0000_0000_0000}, 2 * FRAME_A);

        applyStimulus('0, 2 * FRAME_A);
        wait_for_slot(3, 40);
        frame = '1;
        run_cycles(3 * FRAME_A);

        for (int k = 0; k < 12; k++) begin
            applyStimulus(random_frame(), $urandom_range(1, 600));
        end

        wait_for_slot(4, 58);
        rst_n = 1'b0;
        run_cycles(3);
        frame = random_frame();
        release_reset();
        run_cycles(2 * FRAME_A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
